// File: rtl/ieee_adder_normalize_pack_pkg.sv
// Shared widths, FSM encoding and packing helpers for the adder output stage.
// All other files of the normalise/pack slice import this package.
package ieee_adder_normalize_pack_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int GUARD_W = 3;

    localparam int MANT_W  = 1 + FRAC_W;
    localparam int SIG_W   = MANT_W + GUARD_W;
    localparam int NUM_W   = 1 + EXP_W + FRAC_W;
    localparam int XEXP_W  = EXP_W + 2;

    localparam logic [XEXP_W-1:0] EXP_INF = XEXP_W'((1 << EXP_W) - 1);

    typedef logic [SIG_W-1:0] sig_t;
    typedef logic [NUM_W-1:0] number_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic number_t make_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ieee_adder_normalize_pack_if.sv
// Sum-in / result-out handshake bundle between the add stage and the consumer.
// slave is the normalise/pack block, master is whoever feeds it and drains it.
interface ieee_adder_normalize_pack_if;
    import ieee_adder_normalize_pack_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exponent;
    logic              in_carry;
    sig_t              in_significand;
    logic              out_valid;
    logic              out_ready;
    number_t           out_number;
    logic              out_overflow;
    logic              out_inexact;

    modport master (
        output in_valid, in_sign, in_exponent, in_carry, in_significand, out_ready,
        input  in_ready, out_valid, out_number, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_carry, in_significand, out_ready,
        output in_ready, out_valid, out_number, out_overflow, out_inexact
    );

endinterface

// File: rtl/ieee_round_nearest_even.sv
// Round-to-nearest-even of a 24-bit mantissa given its G/R/S bits.
// Purely combinational; carry_o flags the mantissa wrapping to zero.
module ieee_round_nearest_even
    import ieee_adder_normalize_pack_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic              g_bit_i,
    input  logic              r_bit_i,
    input  logic              s_bit_i,
    output logic [MANT_W-1:0] mant_o,
    output logic              carry_o,
    output logic              inexact_o
);

    logic increment;

    // Ties (G set, nothing below) round towards an even LSB.
    assign increment = g_bit_i & (r_bit_i | s_bit_i | mant_i[0]);
    assign {carry_o, mant_o} = {1'b0, mant_i} + (MANT_W + 1)'(increment);
    assign inexact_o = g_bit_i | r_bit_i | s_bit_i;

endmodule

// File: rtl/ieee_adder_normalize_pack.sv
// Normalises the raw adder sum one left shift per cycle, rounds to nearest-even
// and packs an IEEE single, handing it out under a valid/ready handshake.
module ieee_adder_normalize_pack
    import ieee_adder_normalize_pack_pkg::*;
(
    input  logic clk,
    input  logic reset,
    ieee_adder_normalize_pack_if.slave bus
);

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              carry_q, carry_d;
    logic [XEXP_W-1:0] exp_q, exp_d;
    sig_t              sig_q, sig_d;
    number_t           number_q, number_d;
    logic              ovf_q, ovf_d;
    logic              inex_q, inex_d;

    sig_t              align_sig;
    logic [XEXP_W-1:0] align_exp;
    logic [MANT_W-1:0] rnd_mant;
    logic              rnd_carry;
    logic              rnd_inexact;
    logic [MANT_W-1:0] post_mant;
    logic [XEXP_W-1:0] post_exp;

    // Carry enters the MSB; the two bits falling off collapse into sticky.
    assign align_sig = carry_q ? {1'b1, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]} : sig_q;
    assign align_exp = exp_q + XEXP_W'(carry_q);

    ieee_round_nearest_even u_round (
        .mant_i    (sig_q[SIG_W-1:GUARD_W]),
        .g_bit_i   (sig_q[2]),
        .r_bit_i   (sig_q[1]),
        .s_bit_i   (sig_q[0]),
        .mant_o    (rnd_mant),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    // A rounding carry leaves an all-zero mantissa, so renormalising is just the hidden 1.
    assign post_mant = rnd_carry ? {1'b1, rnd_mant[MANT_W-1:1]} : rnd_mant;
    assign post_exp  = exp_q + XEXP_W'(rnd_carry);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        number_d = number_q;
        ovf_d    = ovf_q;
        inex_d   = inex_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    carry_d = bus.in_carry;
                    sig_d   = bus.in_significand;
                    exp_d   = (bus.in_exponent == '0) ? XEXP_W'(1) : XEXP_W'(bus.in_exponent);
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                sig_d = align_sig;
                exp_d = align_exp;
                if (align_sig == '0) begin
                    number_d = '0;
                    ovf_d    = 1'b0;
                    inex_d   = 1'b0;
                    state_d  = ST_DONE;
                end else if (align_exp >= EXP_INF) begin
                    number_d = make_inf(sign_q);
                    ovf_d    = 1'b1;
                    inex_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Exponent 1 is the denormal floor: stop shifting there.
                if (sig_q[SIG_W-1] || exp_q == XEXP_W'(1)) begin
                    state_d = ST_ROUND;
                end else begin
                    sig_d = {sig_q[SIG_W-2:0], 1'b0};
                    exp_d = exp_q - XEXP_W'(1);
                end
            end
            ST_ROUND: begin
                inex_d  = rnd_inexact;
                state_d = ST_DONE;
                if (post_exp >= EXP_INF) begin
                    number_d = make_inf(sign_q);
                    ovf_d    = 1'b1;
                end else begin
                    number_d = {sign_q,
                                post_mant[MANT_W-1] ? post_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                                post_mant[FRAC_W-1:0]};
                    ovf_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            number_q <= '0;
            ovf_q    <= 1'b0;
            inex_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            number_q <= number_d;
            ovf_q    <= ovf_d;
            inex_q   <= inex_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.out_number   = number_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_inexact  = inex_q;

endmodule

// File: tb/tb_ieee_adder_normalize_pack.sv
// Directed bench for the adder normalise/pack stage: hand-computed IEEE results,
// latency, backpressure hold and asynchronous reset during normalisation.
module tb_ieee_adder_normalize_pack;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ieee_adder_normalize_pack_if bus_if ();

    ieee_adder_normalize_pack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sum, wait (bounded) for out_valid; result stays pending in DONE.
    task automatic run_sum(input logic s, input logic [7:0] e, input logic c,
                           input logic [26:0] sig, output logic [31:0] num,
                           output logic ovf, output logic inx, output int lat);
        n_vec++;
        if (bus_if.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: in_ready=%b required 1", bus_if.in_ready);
        end
        bus_if.in_valid       = 1'b1;
        bus_if.in_sign        = s;
        bus_if.in_exponent    = e;
        bus_if.in_carry       = c;
        bus_if.in_significand = sig;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (bus_if.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 64) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: out_valid never rose within 64 cycles");
        end
        num = bus_if.out_number;
        ovf = bus_if.out_overflow;
        inx = bus_if.out_inexact;
        $display("sum s=%b e=%0d c=%b sig=%07h -> %08h ovf=%b inx=%b lat=%0d",
                 s, e, c, sig, num, ovf, inx, lat);
    endtask

    task automatic accept_output();
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_vec += 5;
        if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus_if.in_ready); end
        if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus_if.out_valid); end
        if (bus_if.out_number !== 32'h0) begin n_err++; $display("FAIL rst_number: got %08h want 00000000", bus_if.out_number); end
        if (bus_if.out_overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", bus_if.out_overflow); end
        if (bus_if.out_inexact !== 1'b0) begin n_err++; $display("FAIL rst_inexact: got %b want 0", bus_if.out_inexact); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_plus_one();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b0, 8'd127, 1'b1, 27'h0000000, num, ovf, inx, lat);
        n_vec += 4;
        if (num !== 32'h40000000) begin n_err++; $display("FAIL one_plus_one: got %08h want 40000000", num); end
        if (inx !== 1'b0) begin n_err++; $display("FAIL one_plus_one_inexact: got %b want 0", inx); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL one_plus_one_ovf: got %b want 0", ovf); end
        if (lat !== 3) begin n_err++; $display("FAIL one_plus_one_latency: got %0d want 3", lat); end
        accept_output();
    endtask

    task automatic test_cancellation();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b0, 8'd127, 1'b0, 27'h1000000, num, ovf, inx, lat);
        n_vec += 3;
        if (num !== 32'h3E800000) begin n_err++; $display("FAIL cancel: got %08h want 3E800000", num); end
        if (inx !== 1'b0) begin n_err++; $display("FAIL cancel_inexact: got %b want 0", inx); end
        if (lat !== 5) begin n_err++; $display("FAIL cancel_latency: got %0d want 5", lat); end
        accept_output();
    endtask

    task automatic test_zero();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b1, 8'd127, 1'b0, 27'h0000000, num, ovf, inx, lat);
        n_vec += 3;
        if (num !== 32'h00000000) begin n_err++; $display("FAIL zero: got %08h want 00000000", num); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b want 0", ovf); end
        if (inx !== 1'b0) begin n_err++; $display("FAIL zero_inexact: got %b want 0", inx); end
        accept_output();
    endtask

    task automatic test_overflow();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b0, 8'd254, 1'b1, 27'h0000000, num, ovf, inx, lat);
        n_vec += 2;
        if (num !== 32'h7F800000) begin n_err++; $display("FAIL overflow: got %08h want 7F800000", num); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b want 1", ovf); end
        accept_output();
        // Rounding carry at the top exponent must saturate as well.
        run_sum(1'b1, 8'd254, 1'b0, 27'h7FFFFFC, num, ovf, inx, lat);
        n_vec += 2;
        if (num !== 32'hFF800000) begin n_err++; $display("FAIL round_overflow: got %08h want FF800000", num); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL round_overflow_flag: got %b want 1", ovf); end
        accept_output();
    endtask

    task automatic test_rounding();
        logic [26:0] sig_tab [3];
        logic [31:0] num_tab [3];
        logic [31:0] num; logic ovf, inx; int lat;
        sig_tab[0] = 27'h400000C; num_tab[0] = 32'h3F800002;
        sig_tab[1] = 27'h4000004; num_tab[1] = 32'h3F800000;
        sig_tab[2] = 27'h7FFFFFC; num_tab[2] = 32'h40000000;
        for (int i = 0; i < 3; i++) begin
            run_sum(1'b0, 8'd127, 1'b0, sig_tab[i], num, ovf, inx, lat);
            n_vec += 3;
            if (num !== num_tab[i]) begin n_err++; $display("FAIL round[%0d]: got %08h want %08h", i, num, num_tab[i]); end
            if (inx !== 1'b1) begin n_err++; $display("FAIL round_inexact[%0d]: got %b want 1", i, inx); end
            if (ovf !== 1'b0) begin n_err++; $display("FAIL round_ovf[%0d]: got %b want 0", i, ovf); end
            accept_output();
        end
    endtask

    task automatic test_denormal();
        logic [7:0]  exp_tab [3];
        logic [26:0] sig_tab [3];
        logic [31:0] num_tab [3];
        logic [31:0] num; logic ovf, inx; int lat;
        exp_tab[0] = 8'd1; sig_tab[0] = 27'h2000000; num_tab[0] = 32'h00400000;
        exp_tab[1] = 8'd1; sig_tab[1] = 27'h0800000; num_tab[1] = 32'h00100000;
        exp_tab[2] = 8'd0; sig_tab[2] = 27'h2000000; num_tab[2] = 32'h00400000;
        for (int i = 0; i < 3; i++) begin
            run_sum(1'b0, exp_tab[i], 1'b0, sig_tab[i], num, ovf, inx, lat);
            n_vec += 2;
            if (num !== num_tab[i]) begin n_err++; $display("FAIL denorm[%0d]: got %08h want %08h", i, num, num_tab[i]); end
            if (lat !== 3) begin n_err++; $display("FAIL denorm_latency[%0d]: got %0d want 3", i, lat); end
            accept_output();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b1, 8'd127, 1'b1, 27'h0000000, num, ovf, inx, lat);
        n_vec++;
        if (num !== 32'hC0000000) begin n_err++; $display("FAIL bp_value: got %08h want C0000000", num); end
        // A competing sum offered while stalled must not be taken.
        bus_if.in_valid       = 1'b1;
        bus_if.in_sign        = 1'b0;
        bus_if.in_exponent    = 8'd100;
        bus_if.in_carry       = 1'b0;
        bus_if.in_significand = 27'h4000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec += 3;
            if (bus_if.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus_if.out_valid); end
            if (bus_if.out_number !== 32'hC0000000) begin n_err++; $display("FAIL bp_hold[%0d]: got %08h want C0000000", i, bus_if.out_number); end
            if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus_if.in_ready); end
        end
        bus_if.out_ready = 1'b1;
        #1;
        n_vec++;
        if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL handoff_in_ready: got %b want 0", bus_if.in_ready); end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        n_vec += 2;
        if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL handoff_valid: got %b want 0", bus_if.out_valid); end
        if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL handoff_idle: got %b want 1", bus_if.in_ready); end
    endtask

    task automatic test_reset_mid_shift();
        bus_if.in_valid       = 1'b1;
        bus_if.in_sign        = 1'b0;
        bus_if.in_exponent    = 8'd127;
        bus_if.in_carry       = 1'b0;
        bus_if.in_significand = 27'h0000008;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_vec += 2;
        if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus_if.in_ready); end
        if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", bus_if.out_valid); end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_vec++;
        if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_dropped: got %b want 0", bus_if.out_valid); end
        $display("reset mid-SHIFT: in_ready=%b out_valid=%b", bus_if.in_ready, bus_if.out_valid);
    endtask

    task automatic test_back_to_back();
        logic [31:0] num; logic ovf, inx; int lat;
        run_sum(1'b1, 8'd127, 1'b0, 27'h4000000, num, ovf, inx, lat);
        n_vec++;
        if (num !== 32'hBF800000) begin n_err++; $display("FAIL b2b_first: got %08h want BF800000", num); end
        accept_output();
        run_sum(1'b0, 8'd130, 1'b0, 27'h6000000, num, ovf, inx, lat);
        n_vec += 2;
        if (num !== 32'h41400000) begin n_err++; $display("FAIL b2b_second: got %08h want 41400000", num); end
        if (inx !== 1'b0) begin n_err++; $display("FAIL b2b_inexact: got %b want 0", inx); end
        accept_output();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus_if.in_valid       = 1'b0;
        bus_if.in_sign        = 1'b0;
        bus_if.in_exponent    = '0;
        bus_if.in_carry       = 1'b0;
        bus_if.in_significand = '0;
        bus_if.out_ready      = 1'b0;
        test_reset();
        test_one_plus_one();
        test_cancellation();
        test_zero();
        test_overflow();
        test_rounding();
        test_denormal();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
